// File: rtl/fluxo_dados_busca_n_pkg.sv
// Shared definitions for the search datapath: state codes, sweep
// direction codes and a small state-decoding helper.
package fluxo_dados_busca_n_pkg;

  typedef logic [2:0] estado_t;

  localparam estado_t INICIAL   = 3'd0;
  localparam estado_t PREPARA   = 3'd1;
  localparam estado_t BUSCA     = 3'd2;
  localparam estado_t ACHOU     = 3'd3;
  localparam estado_t NAO_ACHOU = 3'd4;

  localparam logic SUBIR  = 1'b0;
  localparam logic DESCER = 1'b1;

  // True for the two states in which a search has concluded.
  function automatic logic estado_final(input estado_t e);
    return (e == ACHOU) || (e == NAO_ACHOU);
  endfunction

endpackage

// File: rtl/fluxo_dados_busca_n_contador.sv
// N-bit up/down counter with synchronous clear, synchronous load and
// count enable. o_rco flags the terminal value for the current
// direction: all ones when counting up, zero when counting down.
module contador_updown_n
  import fluxo_dados_busca_n_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         i_zera,
  input  logic         i_carrega,
  input  logic         i_conta,
  input  logic         i_direcao,
  input  logic [N-1:0] i_dado,
  output logic [N-1:0] o_q,
  output logic         o_rco
);

  localparam logic [N-1:0] UM = N'(1);

  logic [N-1:0] r_q;

  // Clear wins over load, load wins over counting.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_q <= '0;
    end else if (i_zera) begin
      r_q <= '0;
    end else if (i_carrega) begin
      r_q <= i_dado;
    end else if (i_conta) begin
      if (i_direcao == DESCER) begin
        r_q <= r_q - UM;
      end else begin
        r_q <= r_q + UM;
      end
    end
  end

  assign o_q   = r_q;
  assign o_rco = (i_direcao == DESCER) ? (r_q == '0) : (r_q == '1);

endmodule

// File: rtl/hexa7seg.sv
// Hex digit to 7-segment decoder for the board displays.
// Segments are active-low, ordered {g,f,e,d,c,b,a}.
module hexa7seg (
  input  logic [3:0] i_hexa,
  output logic [6:0] o_display
);

  // Pure lookup from nibble value to segment pattern.
  always_comb begin
    o_display = 7'b1111111;
    case (i_hexa)
      4'h0: o_display = 7'b1000000;
      4'h1: o_display = 7'b1111001;
      4'h2: o_display = 7'b0100100;
      4'h3: o_display = 7'b0110000;
      4'h4: o_display = 7'b0011001;
      4'h5: o_display = 7'b0010010;
      4'h6: o_display = 7'b0000010;
      4'h7: o_display = 7'b1111000;
      4'h8: o_display = 7'b0000000;
      4'h9: o_display = 7'b0010000;
      4'hA: o_display = 7'b0001000;
      4'hB: o_display = 7'b0000011;
      4'hC: o_display = 7'b1000110;
      4'hD: o_display = 7'b0100001;
      4'hE: o_display = 7'b0000110;
      4'hF: o_display = 7'b0001110;
      default: o_display = 7'b1111111;
    endcase
  end

endmodule

// File: rtl/fluxo_dados_busca_n.sv
// Search datapath: a loaded up/down counter sweeps toward its terminal
// value while being compared with a registered target. The sweep stops
// on a match or on reaching the terminal value, never wrapping around.
// The count is mirrored on DIGITOS hex displays for debugging.
module fluxo_dados_busca_n
  import fluxo_dados_busca_n_pkg::*;
#(
  parameter  int N       = 4,
  localparam int DIGITOS = N / 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 iniciar,
  input  logic                 cancelar,
  input  logic                 modo,
  input  logic [N-1:0]         valor_inicial,
  input  logic [N-1:0]         chaves,
  output logic [N-1:0]         contagem,
  output logic                 menor,
  output logic                 maior,
  output logic                 igual,
  output logic                 fim,
  output logic                 pronto,
  output logic                 achou,
  output logic [2:0]           db_estado,
  output logic [7*DIGITOS-1:0] db_contagem
);

  if ((N % 4) != 0 || N < 4) begin : g_erro_largura
    $error("fluxo_dados_busca_n: N must be a positive multiple of 4");
  end

  estado_t      r_estado;
  logic         r_pronto;
  logic         r_achou;
  logic [N-1:0] r_alvo;
  logic         r_modo;

  estado_t      w_prox;
  logic         w_zera;
  logic         w_carrega;
  logic         w_conta;
  logic [N-1:0] w_contagem;
  logic         w_fim;
  logic         w_igual;

  contador_updown_n #(
    .N(N)
  ) u_contador (
    .clock     (clock),
    .reset     (reset),
    .i_zera    (w_zera),
    .i_carrega (w_carrega),
    .i_conta   (w_conta),
    .i_direcao (r_modo),
    .i_dado    (valor_inicial),
    .o_q       (w_contagem),
    .o_rco     (w_fim)
  );

  assign w_igual = (w_contagem == r_alvo);

  // Next-state and counter control; cancelar overrides everything and
  // unused codes fall back to INICIAL.
  always_comb begin
    w_prox    = INICIAL;
    w_zera    = 1'b0;
    w_carrega = 1'b0;
    w_conta   = 1'b0;
    if (cancelar) begin
      w_prox = INICIAL;
      w_zera = 1'b1;
    end else begin
      case (r_estado)
        INICIAL: begin
          w_prox = iniciar ? PREPARA : INICIAL;
        end
        PREPARA: begin
          w_carrega = 1'b1;
          w_prox    = BUSCA;
        end
        BUSCA: begin
          if (w_igual) begin
            w_prox = ACHOU;
          end else if (w_fim) begin
            w_prox = NAO_ACHOU;
          end else begin
            w_prox  = BUSCA;
            w_conta = 1'b1;
          end
        end
        ACHOU: begin
          w_prox = iniciar ? PREPARA : ACHOU;
        end
        NAO_ACHOU: begin
          w_prox = iniciar ? PREPARA : NAO_ACHOU;
        end
        default: begin
          w_prox = INICIAL;
        end
      endcase
    end
  end

  // State register with pronto/achou decoded from the next state so they
  // line up with the state they describe.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_estado <= INICIAL;
      r_pronto <= 1'b0;
      r_achou  <= 1'b0;
    end else begin
      r_estado <= w_prox;
      r_pronto <= estado_final(w_prox);
      r_achou  <= (w_prox == ACHOU);
    end
  end

  // Target and direction are captured only while preparing a sweep, so
  // switch changes during a search are invisible to it.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_alvo <= '0;
      r_modo <= SUBIR;
    end else if (w_carrega) begin
      r_alvo <= chaves;
      r_modo <= modo;
    end
  end

  assign contagem  = w_contagem;
  assign menor     = (w_contagem < r_alvo);
  assign maior     = (w_contagem > r_alvo);
  assign igual     = w_igual;
  assign fim       = w_fim;
  assign pronto    = r_pronto;
  assign achou     = r_achou;
  assign db_estado = r_estado;

  for (genvar i = 0; i < DIGITOS; i++) begin : g_digitos
    hexa7seg u_hexa (
      .i_hexa    (w_contagem[4*i+3:4*i]),
      .o_display (db_contagem[7*i+6:7*i])
    );
  end

endmodule

// File: tb/tb_fluxo_dados_busca_n.sv
// Bench for the search datapath: directed scenarios plus randomized
// searches, each checked against a search-outcome model.
module tb_fluxo_dados_busca_n;

  logic        clock = 1'b0;
  logic        reset;
  logic        iniciar;
  logic        cancelar;
  logic        modo;
  logic [3:0]  valorInicial;
  logic [3:0]  chaves;
  logic [3:0]  contagem;
  logic        menor, maior, igual, fim, pronto, achou;
  logic [2:0]  dbEstado;
  logic [6:0]  dbContagem;

  logic        iniciar8;
  logic        cancelar8;
  logic        modo8;
  logic [7:0]  valorInicial8;
  logic [7:0]  chaves8;
  logic [7:0]  contagem8;
  logic        menor8, maior8, igual8, fim8, pronto8, achou8;
  logic [2:0]  dbEstado8;
  logic [13:0] dbContagem8;

  int nVetores = 0;
  int nErros   = 0;

  fluxo_dados_busca_n #(.N(4)) dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .cancelar(cancelar),
    .modo(modo), .valor_inicial(valorInicial), .chaves(chaves),
    .contagem(contagem), .menor(menor), .maior(maior), .igual(igual),
    .fim(fim), .pronto(pronto), .achou(achou), .db_estado(dbEstado),
    .db_contagem(dbContagem)
  );

  fluxo_dados_busca_n #(.N(8)) dut8 (
    .clock(clock), .reset(reset), .iniciar(iniciar8), .cancelar(cancelar8),
    .modo(modo8), .valor_inicial(valorInicial8), .chaves(chaves8),
    .contagem(contagem8), .menor(menor8), .maior(maior8), .igual(igual8),
    .fim(fim8), .pronto(pronto8), .achou(achou8), .db_estado(dbEstado8),
    .db_contagem(dbContagem8)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] observado,
                             input logic [31:0] esperado);
    nVetores++;
    if (observado !== esperado) begin
      nErros++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observado, esperado);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Runs one full search on the N=4 instance from any idle/finished state.
  // Outcome: sweeping up from ini reaches alvo only if alvo >= ini, else it
  // stops at 15; sweeping down reaches alvo only if alvo <= ini, else 0.
  task automatic applyStimulus(input int ini, input int alvo, input bit desce);
    int  passos;
    bit  achado;
    int  valor;
    int  final_v;
    if (!desce) begin
      achado = (alvo >= ini);
      passos = achado ? (alvo - ini) : (15 - ini);
    end else begin
      achado = (alvo <= ini);
      passos = achado ? (ini - alvo) : ini;
    end
    final_v = desce ? (ini - passos) : (ini + passos);

    valorInicial = 4'(ini);
    chaves       = 4'(alvo);
    modo         = desce;
    iniciar      = 1'b1;
    tick();
    iniciar = 1'b0;
    tick();
    checkOutput("contagem_carga", 32'(contagem), 32'(ini));
    checkOutput("estado_busca", 32'(dbEstado), 32'd2);
    valorInicial = 4'($urandom);
    chaves       = 4'($urandom);
    modo         = 1'($urandom);
    for (int k = 1; k <= passos; k++) begin
      tick();
      valor = desce ? (ini - k) : (ini + k);
      checkOutput("contagem_passo", 32'(contagem), 32'(valor));
      checkOutput("pronto_busca", 32'(pronto), 32'd0);
    end
    tick();
    checkOutput("estado_final", 32'(dbEstado), achado ? 32'd3 : 32'd4);
    checkOutput("pronto_final", 32'(pronto), 32'd1);
    checkOutput("achou_final", 32'(achou), 32'(achado));
    checkOutput("contagem_final", 32'(contagem), 32'(final_v));
    checkOutput("igual_final", 32'(igual), 32'(achado));
    checkOutput("menor_final", 32'(menor), 32'(final_v < alvo));
    checkOutput("maior_final", 32'(maior), 32'(final_v > alvo));
    checkOutput("fim_final", 32'(fim), 32'(final_v == (desce ? 0 : 15)));
  endtask

  initial begin
    reset = 1'b0; iniciar = 1'b0; cancelar = 1'b0; modo = 1'b0;
    valorInicial = 4'd0; chaves = 4'd0;
    iniciar8 = 1'b0; cancelar8 = 1'b0; modo8 = 1'b0;
    valorInicial8 = 8'd0; chaves8 = 8'd0;
    tick();
    tick();
    checkOutput("reset_estado", 32'(dbEstado), 32'd0);
    checkOutput("reset_contagem", 32'(contagem), 32'd0);
    checkOutput("reset_pronto", 32'(pronto), 32'd0);
    checkOutput("reset_achou", 32'(achou), 32'd0);
    checkOutput("reset_igual", 32'(igual), 32'd1);
    checkOutput("reset_menor", 32'(menor), 32'd0);
    checkOutput("reset_maior", 32'(maior), 32'd0);
    checkOutput("reset_fim", 32'(fim), 32'd0);
    checkOutput("reset_display", 32'(dbContagem), 32'h40);
    #2 reset = 1'b1;
    tick();
    checkOutput("idle_estado", 32'(dbEstado), 32'd0);

    $display("[TB] scenario 1-3: directed searches");
    applyStimulus(2, 5, 1'b0);
    applyStimulus(9, 12, 1'b1);
    applyStimulus(7, 7, 1'b0);
    valorInicial = 4'd15; chaves = 4'd3; modo = 1'b0; iniciar = 1'b1;
    tick();
    iniciar = 1'b0;
    tick();
    checkOutput("fim_imediato", 32'(fim), 32'd1);
    tick();
    checkOutput("nao_achou_imediato", 32'(dbEstado), 32'd4);
    checkOutput("pronto_imediato", 32'(pronto), 32'd1);

    $display("[TB] scenario 4: mid-search input changes and cancel");
    valorInicial = 4'd0; chaves = 4'd10; modo = 1'b0; iniciar = 1'b1;
    tick();
    iniciar = 1'b0;
    tick();
    checkOutput("s4_carga", 32'(contagem), 32'd0);
    for (int k = 1; k <= 10; k++) begin
      tick();
      checkOutput("s4_contagem", 32'(contagem), 32'(k));
      checkOutput("s4_pronto", 32'(pronto), 32'd0);
      if (k == 3) begin
        chaves  = 4'd1;
        iniciar = 1'b1;
      end
      if (k == 5) iniciar = 1'b0;
    end
    tick();
    checkOutput("s4_achou_estado", 32'(dbEstado), 32'd3);
    checkOutput("s4_achou_contagem", 32'(contagem), 32'd10);
    chaves = 4'd10; iniciar = 1'b1;
    tick();
    iniciar = 1'b0;
    tick();
    for (int k = 1; k <= 4; k++) tick();
    checkOutput("s4_antes_cancelar", 32'(contagem), 32'd4);
    cancelar = 1'b1;
    tick();
    cancelar = 1'b0;
    checkOutput("s4_cancel_estado", 32'(dbEstado), 32'd0);
    checkOutput("s4_cancel_contagem", 32'(contagem), 32'd0);
    checkOutput("s4_alvo_mantido", 32'(menor), 32'd1);
    tick();
    checkOutput("s4_ocioso", 32'(dbEstado), 32'd0);

    $display("[TB] scenario 5: asynchronous reset mid-search");
    valorInicial = 4'd3; chaves = 4'd12; modo = 1'b0; iniciar = 1'b1;
    tick();
    iniciar = 1'b0;
    tick(); tick(); tick();
    checkOutput("s5_antes_reset", 32'(contagem), 32'd5);
    #2 reset = 1'b0;
    #1;
    checkOutput("s5_reset_estado", 32'(dbEstado), 32'd0);
    checkOutput("s5_reset_contagem", 32'(contagem), 32'd0);
    checkOutput("s5_reset_pronto", 32'(pronto), 32'd0);
    checkOutput("s5_reset_igual", 32'(igual), 32'd1);
    tick();
    #2 reset = 1'b1;
    tick();
    applyStimulus(2, 5, 1'b0);

    $display("[TB] scenario 6: N=8 display");
    valorInicial8 = 8'hA0; chaves8 = 8'hA5; modo8 = 1'b0; iniciar8 = 1'b1;
    tick();
    iniciar8 = 1'b0;
    tick();
    checkOutput("s6_carga", 32'(contagem8), 32'hA0);
    for (int k = 1; k <= 5; k++) tick();
    checkOutput("s6_contagem", 32'(contagem8), 32'hA5);
    checkOutput("s6_pronto_cedo", 32'(pronto8), 32'd0);
    tick();
    checkOutput("s6_estado", 32'(dbEstado8), 32'd3);
    checkOutput("s6_achou", 32'(achou8), 32'd1);
    checkOutput("s6_digito_baixo", 32'(dbContagem8[6:0]), 32'(7'b0010010));
    checkOutput("s6_digito_alto", 32'(dbContagem8[13:7]), 32'(7'b0001000));

    $display("[TB] randomized searches");
    for (int n = 0; n < 30; n++) begin
      int gap;
      gap = int'($urandom_range(0, 2));
      for (int g = 0; g < gap; g++) tick();
      applyStimulus(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                    1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVetores, nErros);
    $finish;
  end

endmodule
